reg_responder: RTL and testbench

REG_RESPONDER -- requirements
Module: reg_responder

---
 rtl/reg_responder.sv | 164 ++++++++++++++++
 tb/tb_reg_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_responder.sv
// Host-command to register-bus responder: executes read/write commands and writes back data/status.
// Optional REQ timeout enabled by defining REGRESP_TIMEOUT_EN.
module reg_responder #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          SYS_CLK,
  input  logic          RST,
  input  logic          COMM_VALID,
  input  logic [127:0]  COMM_DATA,
  output logic          DATA_VALID,
  output logic [63:0]   DATA_RBACK,
  output logic [63:0]   DATA_MASK,
  output logic [1:0]    DATA_OFFSET,
  output logic          REG_REQ,
  output logic          REG_WE,
  output logic [31:0]   REG_ADDR,
  output logic [63:0]   REG_WDATA,
  input  logic          REG_ACK,
  input  logic [63:0]   REG_RDATA,
  output logic          BUSY,
  output logic [7:0]    DROP_CNT
);

  typedef enum logic [1:0] {IDLE, REQ, RESP_DATA, RESP_STAT} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("reg_responder: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t       state_reg, state_next;
  logic [7:0]   status_reg, status_next;
  logic         comm_valid_reg;
  logic         armed_reg;
  logic         we_reg;
  logic [31:0]  addr_reg;
  logic [63:0]  wdata_reg;
  logic [63:0]  rdata_reg;
  logic [7:0]   drop_cnt_reg;
  logic         comm_rise;
  logic         accept;
  logic         op_read, op_write;
  logic         timeout_hit;
  logic         unused_cmd_bits;

  assign unused_cmd_bits = ^COMM_DATA[31:8];

  // armed_reg keeps a COMM_VALID held high across reset from looking like a fresh edge
  assign comm_rise = COMM_VALID && !comm_valid_reg && armed_reg;
  assign accept    = comm_rise && (state_reg == IDLE);
  assign op_read   = (COMM_DATA[7:0] == 8'h01);
  assign op_write  = (COMM_DATA[7:0] == 8'h02);

`ifdef REGRESP_TIMEOUT_EN
  logic [15:0] wait_cnt_reg;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST)
      wait_cnt_reg <= '0;
    else if (state_reg != REQ)
      wait_cnt_reg <= '0;
    else
      wait_cnt_reg <= wait_cnt_reg + 16'd1;
  end

  assign timeout_hit = (wait_cnt_reg == WAIT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      status_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      status_reg <= status_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    status_next = status_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (op_read || op_write) begin
            state_next = REQ;
          end else begin
            state_next  = RESP_STAT;
            status_next = 8'h81;
          end
        end
      end
      REQ: begin
        if (REG_ACK) begin
          status_next = 8'h80;
          state_next  = we_reg ? RESP_STAT : RESP_DATA;
        end else if (timeout_hit) begin
          status_next = 8'h82;
          state_next  = RESP_STAT;
        end
      end
      RESP_DATA: state_next = RESP_STAT;
      RESP_STAT: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      comm_valid_reg <= 1'b0;
      armed_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      comm_valid_reg <= COMM_VALID;
      if (!COMM_VALID)
        armed_reg <= 1'b1;
      if (accept) begin
        we_reg    <= op_write;
        addr_reg  <= COMM_DATA[63:32];
        wdata_reg <= COMM_DATA[127:64];
      end
      if (comm_rise && (state_reg != IDLE) && (drop_cnt_reg != 8'hFF))
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      if ((state_reg == REQ) && REG_ACK)
        rdata_reg <= REG_RDATA;
    end
  end

  always_comb begin
    DATA_VALID  = 1'b0;
    DATA_RBACK  = '0;
    DATA_MASK   = '0;
    DATA_OFFSET = 2'b00;
    case (state_reg)
      RESP_DATA: begin
        DATA_VALID  = 1'b1;
        DATA_RBACK  = rdata_reg;
        DATA_MASK   = '1;
        DATA_OFFSET = 2'b11;
      end
      RESP_STAT: begin
        DATA_VALID  = 1'b1;
        DATA_RBACK  = {32'h0, status_reg, 24'h0};
        DATA_MASK   = 64'h00000000_FF000000;
        DATA_OFFSET = 2'b10;
      end
      default: ;
    endcase
  end

  assign REG_REQ   = (state_reg == REQ);
  assign REG_WE    = REG_REQ && we_reg;
  assign REG_ADDR  = REG_REQ ? addr_reg : 32'h0;
  assign REG_WDATA = REG_REQ ? wdata_reg : 64'h0;
  assign BUSY      = (state_reg != IDLE);
  assign DROP_CNT  = drop_cnt_reg;

endmodule

// File: tb/tb_reg_responder.sv
// Directed self-checking bench for reg_responder (timeout scenario when REGRESP_TIMEOUT_EN is defined).
module tb_reg_responder;

  logic          SYS_CLK = 1'b0;
  logic          RST;
  logic          COMM_VALID;
  logic [127:0]  COMM_DATA;
  logic          DATA_VALID;
  logic [63:0]   DATA_RBACK;
  logic [63:0]   DATA_MASK;
  logic [1:0]    DATA_OFFSET;
  logic          REG_REQ;
  logic          REG_WE;
  logic [31:0]   REG_ADDR;
  logic [63:0]   REG_WDATA;
  logic          REG_ACK;
  logic [63:0]   REG_RDATA;
  logic          BUSY;
  logic [7:0]    DROP_CNT;

  int total = 0;
  int bad   = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  reg_responder #(.TIMEOUT_CYCLES(4)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST),
    .COMM_VALID(COMM_VALID), .COMM_DATA(COMM_DATA),
    .DATA_VALID(DATA_VALID), .DATA_RBACK(DATA_RBACK),
    .DATA_MASK(DATA_MASK), .DATA_OFFSET(DATA_OFFSET),
    .REG_REQ(REG_REQ), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR),
    .REG_WDATA(REG_WDATA), .REG_ACK(REG_ACK), .REG_RDATA(REG_RDATA),
    .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_wb(input string tag);
    chk({tag, "_dv"}, 64'(DATA_VALID), 64'd0);
    chk({tag, "_rback"}, DATA_RBACK, 64'd0);
    chk({tag, "_mask"}, DATA_MASK, 64'd0);
    chk({tag, "_off"}, 64'(DATA_OFFSET), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; COMM_VALID = 1'b0; COMM_DATA = '0; REG_ACK = 1'b0; REG_RDATA = '0;
    repeat (3) @(posedge SYS_CLK);
    #1;
    chk_idle_wb("rst");
    chk("rst_req", 64'(REG_REQ), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_drop", 64'(DROP_CNT), 64'd0);
    RST = 1'b0;
    tick();

    // read transaction
    COMM_DATA = {64'h0, 32'h0000_0040, 24'h0, 8'h01};
    COMM_VALID = 1'b1;
    tick();
    COMM_VALID = 1'b0; COMM_DATA = '0;
    chk("rd_req", 64'(REG_REQ), 64'd1);
    chk("rd_we", 64'(REG_WE), 64'd0);
    chk("rd_addr", 64'(REG_ADDR), 64'h40);
    chk("rd_busy", 64'(BUSY), 64'd1);
    chk_idle_wb("rd_wait");
    tick();
    tick();
    chk("rd_addr_stable", 64'(REG_ADDR), 64'h40);
    REG_ACK = 1'b1; REG_RDATA = 64'hDEAD_BEEF_0123_4567;
    tick();
    REG_ACK = 1'b0; REG_RDATA = '0;
    chk("rd_d_dv", 64'(DATA_VALID), 64'd1);
    chk("rd_d_off", 64'(DATA_OFFSET), 64'd3);
    chk("rd_d_rback", DATA_RBACK, 64'hDEAD_BEEF_0123_4567);
    chk("rd_d_mask", DATA_MASK, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rd_d_req", 64'(REG_REQ), 64'd0);
    tick();
    chk("rd_s_dv", 64'(DATA_VALID), 64'd1);
    chk("rd_s_off", 64'(DATA_OFFSET), 64'd2);
    chk("rd_s_rback", DATA_RBACK, 64'h0000_0000_8000_0000);
    chk("rd_s_mask", DATA_MASK, 64'h0000_0000_FF00_0000);
    tick();
    chk_idle_wb("rd_done");
    chk("rd_done_busy", 64'(BUSY), 64'd0);

    // write transaction, ACK coincident with acceptance is ignored, second edge dropped
    COMM_DATA = {64'h55, 32'h10, 24'h0, 8'h02};
    COMM_VALID = 1'b1; REG_ACK = 1'b1;
    tick();
    COMM_VALID = 1'b0; REG_ACK = 1'b0; COMM_DATA = '0;
    tick();
    chk("wr_ack_at_accept_ignored", 64'(REG_REQ), 64'd1);
    COMM_DATA = {64'h99, 32'h77, 24'h0, 8'h01};
    COMM_VALID = 1'b1;
    tick();
    chk("wr_drop1", 64'(DROP_CNT), 64'd1);
    chk("wr_req", 64'(REG_REQ), 64'd1);
    chk("wr_we", 64'(REG_WE), 64'd1);
    chk("wr_addr", 64'(REG_ADDR), 64'h10);
    chk("wr_wdata", REG_WDATA, 64'h55);
    REG_ACK = 1'b1;
    tick();
    REG_ACK = 1'b0;
    chk("wr_s_dv", 64'(DATA_VALID), 64'd1);
    chk("wr_s_off", 64'(DATA_OFFSET), 64'd2);
    chk("wr_s_rback", DATA_RBACK, 64'h0000_0000_8000_0000);
    chk("wr_s_req", 64'(REG_REQ), 64'd0);
    tick();
    chk_idle_wb("wr_done");
    tick();
    chk("wr_dropped_not_run", 64'(BUSY), 64'd0);
    COMM_VALID = 1'b0; COMM_DATA = '0;
    tick();

    // illegal opcode
    COMM_DATA = {64'h0, 32'h20, 24'h0, 8'h7F};
    COMM_VALID = 1'b1;
    tick();
    COMM_VALID = 1'b0;
    chk("ill_req", 64'(REG_REQ), 64'd0);
    chk("ill_dv", 64'(DATA_VALID), 64'd1);
    chk("ill_off", 64'(DATA_OFFSET), 64'd2);
    chk("ill_rback", DATA_RBACK, 64'h0000_0000_8100_0000);
    tick();
    chk_idle_wb("ill_done");
    chk("ill_done_req", 64'(REG_REQ), 64'd0);

`ifdef REGRESP_TIMEOUT_EN
    // timeout with no ACK
    COMM_DATA = {64'h0, 32'h30, 24'h0, 8'h01};
    COMM_VALID = 1'b1;
    tick();
    COMM_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", 64'(REG_REQ), 64'd1);
      if (i < 3) tick();
    end
    tick();
    chk("to_req_low", 64'(REG_REQ), 64'd0);
    chk("to_s_dv", 64'(DATA_VALID), 64'd1);
    chk("to_s_off", 64'(DATA_OFFSET), 64'd2);
    chk("to_s_rback", DATA_RBACK, 64'h0000_0000_8200_0000);
    REG_ACK = 1'b1;
    tick();
    REG_ACK = 1'b0;
    chk_idle_wb("to_late_ack");
    chk("to_late_busy", 64'(BUSY), 64'd0);
`else
    // no timeout: REQ waits indefinitely; drops saturate
    COMM_DATA = {64'h0, 32'h30, 24'h0, 8'h01};
    COMM_VALID = 1'b1;
    tick();
    COMM_VALID = 1'b0;
    for (int i = 0; i < 300; i++) begin
      COMM_VALID = 1'b1;
      tick();
      COMM_VALID = 1'b0;
      tick();
    end
    chk("nto_req_held", 64'(REG_REQ), 64'd1);
    chk("nto_no_wb", 64'(DATA_VALID), 64'd0);
    chk("drop_sat", 64'(DROP_CNT), 64'hFF);
    REG_ACK = 1'b1; REG_RDATA = 64'h1234;
    tick();
    REG_ACK = 1'b0;
    chk("nto_d_off", 64'(DATA_OFFSET), 64'd3);
    tick();
    chk("nto_s_rback", DATA_RBACK, 64'h0000_0000_8000_0000);
    tick();
`endif

    // reset mid-transaction with COMM_VALID held high across it
    COMM_DATA = {64'h0, 32'h50, 24'h0, 8'h01};
    COMM_VALID = 1'b1;
    tick();
    chk("mr_req_before", 64'(REG_REQ), 64'd1);
    #2 RST = 1'b1;
    #1;
    chk("mr_req", 64'(REG_REQ), 64'd0);
    chk("mr_busy", 64'(BUSY), 64'd0);
    chk("mr_drop", 64'(DROP_CNT), 64'd0);
    chk("mr_addr", 64'(REG_ADDR), 64'd0);
    chk_idle_wb("mr");
    tick();
    RST = 1'b0;
    REG_ACK = 1'b1;
    tick();
    REG_ACK = 1'b0;
    chk_idle_wb("mr_post_ack");
    tick();
    chk("mr_held_not_accepted", 64'(BUSY), 64'd0);
    chk("mr_held_req", 64'(REG_REQ), 64'd0);
    COMM_VALID = 1'b0;
    tick();
    COMM_VALID = 1'b1;
    tick();
    COMM_VALID = 1'b0;
    chk("mr_reaccept_req", 64'(REG_REQ), 64'd1);
    chk("mr_reaccept_addr", 64'(REG_ADDR), 64'h50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
